// File: rtl/dino_pkg.sv
// Shared types and constants for the obstacle scheduler.
// Also provides the LFSR step function.
package dino_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } game_state_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int          SCORE_W   = 16;
   localparam int          PERIOD_W  = 16;

   // A zero state would lock the register, so it falls back to the seed.
   function automatic logic [15:0] lfsr_step(input logic [15:0] cur, input logic [15:0] seed);
      logic [15:0] nxt;
      nxt = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
      if (nxt == 16'h0000) begin
         lfsr_step = seed;
      end else begin
         lfsr_step = nxt;
      end
   endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Game control and status bundle between the game controller and obstacle_scheduler.
interface obstacle_scheduler_if;
   import dino_pkg::*;

   logic                start;
   logic                collision;
   logic                shift_en;
   logic                spawn;
   logic                running;
   logic                game_over;
   logic [SCORE_W-1:0]  score;
   logic [PERIOD_W-1:0] period;

   modport master (
      output start, collision,
      input  shift_en, spawn, running, game_over, score, period
   );

   modport slave (
      input  start, collision,
      output shift_en, spawn, running, game_over, score, period
   );
endinterface

// File: rtl/obstacle_scheduler_lfsr16.sv
// 16-bit Galois LFSR that free-runs every clock; reset loads the seed.
module lfsr16
   import dino_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic [15:0] q_q;
   logic [15:0] q_d;

   // Next LFSR state.
   always_comb begin
      q_d = lfsr_step(q_q, seed);
   end

   // LFSR register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= seed;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Game sequencer: IDLE/RUN/OVER FSM, shift strobe at the current speed,
// gap-limited random spawn bit, periodic speed-up and saturating score.
module obstacle_scheduler
   import dino_pkg::*;
#(
   parameter logic [15:0] INIT_PERIOD   = 16'd50000,
   parameter logic [15:0] MIN_PERIOD    = 16'd10000,
   parameter logic [15:0] PERIOD_STEP   = 16'd2000,
   parameter logic [7:0]  SPEEDUP_EVERY = 8'd32,
   parameter logic [3:0]  MIN_GAP       = 4'd3,
   parameter logic [4:0]  SPAWN_THRESH  = 5'd5,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
)(
   input  logic           clk,
   input  logic           rst_n,
   obstacle_scheduler_if.slave bus
);

   game_state_t         state_q, state_d;
   logic [PERIOD_W-1:0] tick_q, tick_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [7:0]          spd_q, spd_d;
   logic [3:0]          gap_q, gap_d;
   logic                shift_en_q, shift_en_d;
   logic                spawn_q, spawn_d;
   logic                running_q, running_d;
   logic                game_over_q, game_over_d;

   logic [15:0]         lfsr_s;
   logic [11:0]         lfsr_unused_s;
   logic                terminal_s;
   logic                spawn_ok_s;
   logic [16:0]         floor_sum_s;
   logic [PERIOD_W-1:0] period_dec_s;

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .seed  (LFSR_SEED),
      .q     (lfsr_s)
   );

   assign lfsr_unused_s = lfsr_s[15:4];
   assign terminal_s    = (tick_q == (period_q - 16'd1));
   assign spawn_ok_s    = (gap_q >= MIN_GAP) && ({1'b0, lfsr_s[3:0]} < SPAWN_THRESH);
   // 17-bit compare keeps MIN_PERIOD+PERIOD_STEP from wrapping; subtraction then cannot underflow.
   assign floor_sum_s   = {1'b0, MIN_PERIOD} + {1'b0, PERIOD_STEP};
   assign period_dec_s  = ({1'b0, period_q} < floor_sum_s) ? MIN_PERIOD : (period_q - PERIOD_STEP);

   // Next-state and next-output logic for the game FSM and its counters.
   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      period_d    = period_q;
      score_d     = score_q;
      spd_d       = spd_q;
      gap_d       = gap_q;
      shift_en_d  = 1'b0;
      spawn_d     = 1'b0;
      running_d   = running_q;
      game_over_d = game_over_q;

      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (bus.start) begin
               state_d     = ST_RUN;
               running_d   = 1'b1;
               game_over_d = 1'b0;
               score_d     = 16'd0;
               period_d    = INIT_PERIOD;
               tick_d      = 16'd0;
               spd_d       = 8'd0;
               gap_d       = 4'd0;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            // Collision wins over a terminal tick in the same cycle.
            if (bus.collision) begin
               state_d     = ST_OVER;
               running_d   = 1'b0;
               game_over_d = 1'b1;
            end else if (terminal_s) begin
               shift_en_d = 1'b1;
               spawn_d    = spawn_ok_s;
               tick_d     = 16'd0;
               score_d    = (score_q == 16'hFFFF) ? score_q : (score_q + 16'd1);
               if (spawn_ok_s) begin
                  gap_d = 4'd0;
               end else if (gap_q < MIN_GAP) begin
                  gap_d = gap_q + 4'd1;
               end else begin
                  gap_d = gap_q;
               end
               if (spd_q == (SPEEDUP_EVERY - 8'd1)) begin
                  spd_d    = 8'd0;
                  period_d = period_dec_s;
               end else begin
                  spd_d    = spd_q + 8'd1;
               end
            end else begin
               tick_d = tick_q + 16'd1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            running_d   = 1'b0;
            game_over_d = 1'b0;
         end
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         tick_q      <= 16'd0;
         period_q    <= INIT_PERIOD;
         score_q     <= 16'd0;
         spd_q       <= 8'd0;
         gap_q       <= 4'd0;
         shift_en_q  <= 1'b0;
         spawn_q     <= 1'b0;
         running_q   <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         period_q    <= period_d;
         score_q     <= score_d;
         spd_q       <= spd_d;
         gap_q       <= gap_d;
         shift_en_q  <= shift_en_d;
         spawn_q     <= spawn_d;
         running_q   <= running_d;
         game_over_q <= game_over_d;
      end
   end

   assign bus.shift_en  = shift_en_q;
   assign bus.spawn     = spawn_q;
   assign bus.running   = running_q;
   assign bus.game_over = game_over_q;
   assign bus.score     = score_q;
   assign bus.period    = period_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: three instances (spawn threshold 16, 0, default)
// share stimulus; expected timing, score, period and spawn come from closed-form game rules.
module tb_obstacle_scheduler;

   localparam int INIT  = 8;
   localparam int MINP  = 4;
   localparam int STEP  = 2;
   localparam int EVERY = 4;
   localparam int GAP   = 3;

   logic clk         = 1'b0;
   logic rst_n       = 1'b0;
   logic start_s     = 1'b0;
   logic collision_s = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   obstacle_scheduler_if bus   ();
   obstacle_scheduler_if bus_z ();
   obstacle_scheduler_if bus_r ();

   assign bus.start       = start_s;
   assign bus.collision   = collision_s;
   assign bus_z.start     = start_s;
   assign bus_z.collision = collision_s;
   assign bus_r.start     = start_s;
   assign bus_r.collision = collision_s;

   obstacle_scheduler #(
      .INIT_PERIOD(16'd8), .MIN_PERIOD(16'd4), .PERIOD_STEP(16'd2),
      .SPEEDUP_EVERY(8'd4), .MIN_GAP(4'd3), .SPAWN_THRESH(5'd16), .LFSR_SEED(16'hACE1)
   ) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   obstacle_scheduler #(
      .INIT_PERIOD(16'd8), .MIN_PERIOD(16'd4), .PERIOD_STEP(16'd2),
      .SPEEDUP_EVERY(8'd4), .MIN_GAP(4'd3), .SPAWN_THRESH(5'd0), .LFSR_SEED(16'hACE1)
   ) dut_z (.clk(clk), .rst_n(rst_n), .bus(bus_z.slave));

   obstacle_scheduler #(
      .INIT_PERIOD(16'd8), .MIN_PERIOD(16'd4), .PERIOD_STEP(16'd2),
      .SPEEDUP_EVERY(8'd4), .MIN_GAP(4'd3), .SPAWN_THRESH(5'd5), .LFSR_SEED(16'hACE1)
   ) dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r.slave));

   // Interval (cycles) that ends with shift k of a game.
   function automatic int per_before(input int k);
      int p;
      p = INIT - STEP * ((k - 1) / EVERY);
      return (p < MINP) ? MINP : p;
   endfunction

   // Period reported after shift k of a game.
   function automatic int per_after(input int k);
      int p;
      p = INIT - STEP * (k / EVERY);
      return (p < MINP) ? MINP : p;
   endfunction

   // With an always-true threshold, spawns land on every (GAP+1)-th shift.
   function automatic logic spawn_exp(input int k);
      return ((k % (GAP + 1)) == 0) ? 1'b1 : 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
   endtask

   task automatic run_shifts(input int k_first, input int k_last, input int start_at_k);
      for (int k = k_first; k <= k_last; k++) begin
         int iv;
         int early;
         logic [15:0] k16;
         logic [15:0] p16;
         iv    = per_before(k);
         early = 0;
         k16   = k[15:0];
         p16   = 16'(per_after(k));
         for (int c = 1; c < iv; c++) begin
            if (k == start_at_k && c == 2) start_s = 1'b1;
            tick();
            start_s = 1'b0;
            if (bus.shift_en !== 1'b0 || bus.spawn !== 1'b0) early++;
         end
         tick();
         n_chk++;
         if (early !== 0) begin
            n_fail++;
            $display("FAIL early_shift k=%0d: %0d strobes before interval end, required 0", k, early);
         end
         n_chk++;
         if (bus.shift_en !== 1'b1) begin
            n_fail++;
            $display("FAIL shift_en k=%0d: got %b, required 1", k, bus.shift_en);
         end
         n_chk++;
         if (bus.score !== k16) begin
            n_fail++;
            $display("FAIL score k=%0d: got %0d, required %0d", k, bus.score, k16);
         end
         n_chk++;
         if (bus.period !== p16) begin
            n_fail++;
            $display("FAIL period k=%0d: got %0d, required %0d", k, bus.period, p16);
         end
         n_chk++;
         if (bus.spawn !== spawn_exp(k)) begin
            n_fail++;
            $display("FAIL spawn k=%0d: got %b, required %b", k, bus.spawn, spawn_exp(k));
         end
      end
   endtask

   task automatic check_fresh_game(input string tag);
      n_chk++;
      if (bus.running !== 1'b1 || bus.game_over !== 1'b0 || bus.shift_en !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_flags: running=%b game_over=%b shift_en=%b, required 1 0 0",
                  tag, bus.running, bus.game_over, bus.shift_en);
      end
      n_chk++;
      if (bus.score !== 16'd0 || bus.period !== 16'd8) begin
         n_fail++;
         $display("FAIL %s_init: score=%0d period=%0d, required 0 8", tag, bus.score, bus.period);
      end
   endtask

   task automatic test_reset();
      int act;
      rst_n = 1'b0;
      start_s = 1'b0;
      collision_s = 1'b0;
      repeat (3) tick();
      n_chk++;
      if (bus.running !== 1'b0 || bus.game_over !== 1'b0 || bus.shift_en !== 1'b0 || bus.spawn !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: run=%b over=%b shift=%b spawn=%b, required 0 0 0 0",
                  bus.running, bus.game_over, bus.shift_en, bus.spawn);
      end
      n_chk++;
      if (bus.score !== 16'd0 || bus.period !== 16'd8) begin
         n_fail++;
         $display("FAIL reset_vals: score=%0d period=%0d, required 0 8", bus.score, bus.period);
      end
      #3 rst_n = 1'b1;
      act = 0;
      repeat (20) begin
         tick();
         if (bus.running !== 1'b0 || bus.shift_en !== 1'b0) act++;
      end
      n_chk++;
      if (act !== 0) begin
         n_fail++;
         $display("FAIL idle_quiet: %0d active cycles, required 0", act);
      end
   endtask

   task automatic test_first_game();
      repeat ($urandom_range(1, 7)) tick();
      pulse_start();
      check_fresh_game("start");
      run_shifts(1, 14, 0);
   endtask

   task automatic test_collision();
      int extra;
      int last;
      int bad;
      logic [15:0] last16;
      logic [15:0] p16;
      extra = $urandom_range(0, 2);
      last  = 14 + extra;
      run_shifts(15, last, 0);
      last16 = last[15:0];
      p16    = 16'(per_after(last));
      repeat (per_after(last) - 1) tick();
      collision_s = 1'b1;
      tick();
      n_chk++;
      if (bus.shift_en !== 1'b0 || bus.spawn !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_shift: shift_en=%b spawn=%b, required 0 0", bus.shift_en, bus.spawn);
      end
      n_chk++;
      if (bus.running !== 1'b0 || bus.game_over !== 1'b1) begin
         n_fail++;
         $display("FAIL collide_state: running=%b game_over=%b, required 0 1", bus.running, bus.game_over);
      end
      n_chk++;
      if (bus.score !== last16) begin
         n_fail++;
         $display("FAIL collide_score: got %0d, required %0d", bus.score, last16);
      end
      bad = 0;
      repeat (16) begin
         collision_s = 1'($urandom_range(0, 1));
         tick();
         if (bus.shift_en !== 1'b0 || bus.spawn !== 1'b0 || bus.running !== 1'b0 ||
             bus.game_over !== 1'b1 || bus.score !== last16 || bus.period !== p16) bad++;
      end
      collision_s = 1'b0;
      n_chk++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL over_hold: %0d bad cycles, required 0", bad);
      end
   endtask

   task automatic test_restart();
      repeat ($urandom_range(1, 9)) tick();
      pulse_start();
      check_fresh_game("restart");
      run_shifts(1, 6, 3);
   endtask

   task automatic test_async_reset();
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (bus.running !== 1'b0 || bus.shift_en !== 1'b0 || bus.spawn !== 1'b0 || bus.game_over !== 1'b0) begin
         n_fail++;
         $display("FAIL async_flags: run=%b shift=%b spawn=%b over=%b, required 0 0 0 0",
                  bus.running, bus.shift_en, bus.spawn, bus.game_over);
      end
      n_chk++;
      if (bus.score !== 16'd0 || bus.period !== 16'd8) begin
         n_fail++;
         $display("FAIL async_vals: score=%0d period=%0d, required 0 8", bus.score, bus.period);
      end
      repeat (2) tick();
      #3 rst_n = 1'b1;
      repeat ($urandom_range(1, 5)) tick();
      pulse_start();
      check_fresh_game("after_reset");
      run_shifts(1, 8, 0);
   endtask

   // Continuous invariants across all three instances.
   int   since_r;
   logic prev_run_r;
   always @(negedge clk) begin
      if (!rst_n) begin
         since_r    = 0;
         prev_run_r = 1'b0;
      end else begin
         n_chk++;
         if (bus.spawn === 1'b1 && bus.shift_en !== 1'b1) begin
            n_fail++;
            $display("FAIL spawn_no_shift: spawn=%b shift_en=%b", bus.spawn, bus.shift_en);
         end
         n_chk++;
         if (bus_z.spawn !== 1'b0 || bus_z.shift_en !== bus.shift_en) begin
            n_fail++;
            $display("FAIL thresh0: spawn=%b shift_en=%b, required 0 %b", bus_z.spawn, bus_z.shift_en, bus.shift_en);
         end
         n_chk++;
         if (bus_r.spawn === 1'b1 && bus_r.shift_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rnd_spawn_no_shift: spawn=%b shift_en=%b", bus_r.spawn, bus_r.shift_en);
         end
         if (bus_r.running === 1'b1 && prev_run_r !== 1'b1) since_r = 0;
         if (bus_r.shift_en === 1'b1) begin
            if (bus_r.spawn === 1'b1) begin
               n_chk++;
               if (since_r < GAP) begin
                  n_fail++;
                  $display("FAIL rnd_gap: %0d empty shifts before spawn, required >= %0d", since_r, GAP);
               end
               since_r = 0;
            end else begin
               since_r++;
            end
         end
         prev_run_r = bus_r.running;
      end
   end

   initial begin
      test_reset();
      test_first_game();
      test_collision();
      test_restart();
      test_async_reset();
      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
